// File: rtl/data_mem_mmio_if.sv
// Bus bundle for data_mem_mmio: data read, fetch read, write and TX byte stream.
// master = core/UART side, slave = the memory block.
interface data_mem_mmio_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    i_read_req;
  logic [ADDR_WIDTH-1:0]   i_read_addr;
  logic [DATA_WIDTH-1:0]   o_read_data;
  logic [ADDR_WIDTH-1:0]   i_read_fetch_addr;
  logic [DATA_WIDTH-1:0]   o_read_fetch_data;
  logic                    i_write_enable;
  logic [DATA_WIDTH/8-1:0] i_byte_enable;
  logic [ADDR_WIDTH-1:0]   i_write_addr;
  logic [DATA_WIDTH-1:0]   i_write_data;
  logic [7:0]              o_tx_data;
  logic                    o_tx_valid;
  logic                    i_tx_ready;

  modport master (
    output i_read_req, i_read_addr, i_read_fetch_addr,
    output i_write_enable, i_byte_enable, i_write_addr, i_write_data,
    output i_tx_ready,
    input  o_read_data, o_read_fetch_data, o_tx_data, o_tx_valid
  );

  modport slave (
    input  i_read_req, i_read_addr, i_read_fetch_addr,
    input  i_write_enable, i_byte_enable, i_write_addr, i_write_data,
    input  i_tx_ready,
    output o_read_data, o_read_fetch_data, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/data_mem_mmio.sv
// Byte-lane data/fetch memory with an MMIO console TX FIFO and status word.
// Optional macro DATA_MEM_SIM_PRINT_EN echoes pushed bytes in simulation.
module data_mem_mmio #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int UART_ADDR     = 128,
  parameter int STATUS_ADDR   = 129,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  data_mem_mmio_if.slave  bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(DEPTH_WORDS);
  localparam int PW    = $clog2(TX_FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] UART_A   = ADDR_WIDTH'(UART_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(STATUS_ADDR);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [7:0]            fifo [TX_FIFO_DEPTH];

  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] read_q, fetch_q, read_next, status_word;
  logic [31:0]           count_ext;
  logic [7:0]            count_sat;
  logic                  empty, full, mmio_w, push_req, push_ok, pop, ovf_set, ovf_clr;

  wire [IW-1:0] ridx = bus.i_read_addr[IW-1:0];
  wire [IW-1:0] fidx = bus.i_read_fetch_addr[IW-1:0];
  wire [IW-1:0] widx = bus.i_write_addr[IW-1:0];

  assign empty     = (count == '0);
  assign full      = (count == CW'(TX_FIFO_DEPTH));
  assign count_ext = 32'(count);
  assign count_sat = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];

  assign mmio_w   = (bus.i_write_addr == UART_A) || (bus.i_write_addr == STATUS_A);
  assign push_req = clk_en && bus.i_write_enable && (bus.i_write_addr == UART_A) &&
                    bus.i_byte_enable[0];
  assign pop      = clk_en && !empty && bus.i_tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = clk_en && bus.i_read_req && (bus.i_read_addr == STATUS_A);

  always_comb begin
    status_word       = '0;
    status_word[7:0]  = count_sat;
    status_word[8]    = empty;
    status_word[9]    = full;
    status_word[10]   = overflow;
  end

  always_comb begin
    read_next = mem[ridx];
    if (bus.i_read_addr == UART_A)
      read_next = '0;
    else if (bus.i_read_addr == STATUS_A)
      read_next = status_word;
  end

  always_ff @(posedge clk) begin
    if (clk_en && bus.i_write_enable && !mmio_w) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.i_byte_enable[l])
          mem[widx][l*8 +: 8] <= bus.i_write_data[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo[wr_ptr] <= bus.i_write_data[7:0];
  end

  // Nonblocking reads of mem give read-first behaviour against a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q  <= '0;
      fetch_q <= '0;
    end else if (clk_en) begin
      read_q  <= read_next;
      fetch_q <= mem[fidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign bus.o_read_data       = read_q;
  assign bus.o_read_fetch_data = fetch_q;
  assign bus.o_tx_valid        = !empty;
  assign bus.o_tx_data         = empty ? 8'h00 : fifo[rd_ptr];

`ifdef DATA_MEM_SIM_PRINT_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (push_ok)
        $write("%c", bus.i_write_data[7:0]);
      else if (ovf_set)
        $display("warning: tx fifo full, dropped byte 0x%02h", bus.i_write_data[7:0]);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: vector table for memory/MMIO basics,
// hand-written sequences for overflow, full push/pop, clk_en and reset.
module tb_data_mem_mmio;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  data_mem_mmio_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_mem_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        rreq;
    logic [31:0] faddr;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_f;
    logic [31:0] exp_f;
    logic        chk_tx;
    logic        exp_v;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic we, logic [3:0] be, logic [31:0] wa,
                              logic [31:0] wd, logic [31:0] ra, logic rq, logic [31:0] fa,
                              logic rdy, logic crd, logic [31:0] erd, logic cf,
                              logic [31:0] ef, logic ctx, logic ev, logic [7:0] ed);
    vec_t v;
    v.name = nm; v.we = we; v.be = be; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.rreq = rq; v.faddr = fa; v.rdy = rdy;
    v.chk_rd = crd; v.exp_rd = erd; v.chk_f = cf; v.exp_f = ef;
    v.chk_tx = ctx; v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_read_req        = 1'b0;
    bus.i_read_addr       = '0;
    bus.i_read_fetch_addr = '0;
    bus.i_write_enable    = 1'b0;
    bus.i_byte_enable     = '0;
    bus.i_write_addr      = '0;
    bus.i_write_data      = '0;
    bus.i_tx_ready        = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_write_enable = 1'b1;
    bus.i_byte_enable  = 4'b0001;
    bus.i_write_addr   = 32'd128;
    bus.i_write_data   = {24'h0, b};
    tick();
    bus.i_write_enable = 1'b0;
  endtask

  task automatic read_status(string nm, input logic [31:0] exp);
    bus.i_read_req  = 1'b1;
    bus.i_read_addr = 32'd129;
    tick();
    bus.i_read_req  = 1'b0;
    bus.i_read_addr = '0;
    chk(nm, bus.o_read_data, exp);
  endtask

  task automatic drain_expect(string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, {31'h0, bus.o_tx_valid}, 32'h1);
    chk({nm, "_data"}, {24'h0, bus.o_tx_data}, {24'h0, exp});
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_tx_ready = 1'b0;
  endtask

  initial begin
    idle();
    vecs.push_back(mk("w5_full",    1, 4'hF, 5, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("w5_lane2",   1, 4'b0100, 5, 32'hAABBCCDD, 5, 0, 5, 0,
                      1, 32'h11223344, 1, 32'h11223344, 0, 0, 0));
    vecs.push_back(mk("r5_merged",  0, 0, 0, 0, 5, 0, 5, 0,
                      1, 32'h11BB3344, 1, 32'h11BB3344, 0, 0, 0));
    vecs.push_back(mk("w7_init",    1, 4'hF, 7, 32'h01020304, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r7_rdfirst", 1, 4'hF, 7, 32'hDEADBEEF, 7, 0, 7, 0,
                      1, 32'h01020304, 1, 32'h01020304, 0, 0, 0));
    vecs.push_back(mk("r7_new",     0, 0, 0, 0, 7, 0, 7, 0,
                      1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk("w_1027",     1, 4'hF, 1027, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r3_alias",   0, 0, 0, 0, 3, 0, 1027, 0,
                      1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 0, 0));
    vecs.push_back(mk("w_1152",     1, 4'hF, 1152, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r_uart_0",   1, 4'hF, 1153, 32'h66666666, 128, 0, 0, 0,
                      1, 32'h0, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk("st_empty",   0, 0, 0, 0, 129, 1, 0, 0, 1, 32'h100, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk("push_H",     1, 4'b0001, 128, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h48));
    vecs.push_back(mk("push_i",     1, 4'b0001, 128, 32'hFFFFFF69, 0, 0, 0, 0,
                      0, 0, 0, 0, 1, 1, 8'h48));
    vecs.push_back(mk("st_two",     0, 0, 0, 0, 129, 1, 0, 0, 1, 32'h002, 0, 0, 1, 1, 8'h48));
    vecs.push_back(mk("pop_H",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 8'h69));
    vecs.push_back(mk("pop_i",      1, 4'hF, 129, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk("st_drained", 0, 0, 0, 0, 129, 1, 128, 0,
                      1, 32'h100, 1, 32'h55555555, 1, 0, 8'h00));
    vecs.push_back(mk("no_be0_push", 1, 4'b1110, 128, 32'h77777777, 128, 0, 129, 0,
                      1, 32'h0, 1, 32'h66666666, 1, 0, 8'h00));

    // reset state
    tick(); tick();
    chk("rst_rd",    bus.o_read_data, 32'h0);
    chk("rst_fetch", bus.o_read_fetch_data, 32'h0);
    chk("rst_valid", {31'h0, bus.o_tx_valid}, 32'h0);
    chk("rst_txd",   {24'h0, bus.o_tx_data}, 32'h0);
    rst = 1'b0;
    read_status("rst_status", 32'h100);

    foreach (vecs[i]) begin
      bus.i_write_enable    = vecs[i].we;
      bus.i_byte_enable     = vecs[i].be;
      bus.i_write_addr      = vecs[i].waddr;
      bus.i_write_data      = vecs[i].wdata;
      bus.i_read_addr       = vecs[i].raddr;
      bus.i_read_req        = vecs[i].rreq;
      bus.i_read_fetch_addr = vecs[i].faddr;
      bus.i_tx_ready        = vecs[i].rdy;
      tick();
      if (vecs[i].chk_rd) chk({vecs[i].name, "_rd"}, bus.o_read_data, vecs[i].exp_rd);
      if (vecs[i].chk_f)  chk({vecs[i].name, "_fetch"}, bus.o_read_fetch_data, vecs[i].exp_f);
      if (vecs[i].chk_tx) begin
        chk({vecs[i].name, "_valid"}, {31'h0, bus.o_tx_valid}, {31'h0, vecs[i].exp_v});
        chk({vecs[i].name, "_txd"}, {24'h0, bus.o_tx_data}, {24'h0, vecs[i].exp_d});
      end
    end
    idle();

    // overflow: 17 pushes into 16 entries, sticky flag cleared by status read
    for (int k = 0; k < 17; k++) push(8'h30 + 8'(k));
    read_status("ovf_status", 32'h610);
    read_status("ovf_cleared", 32'h210);
    for (int k = 0; k < 16; k++) drain_expect("ovf_drain", 8'h30 + 8'(k));
    chk("ovf_empty", {31'h0, bus.o_tx_valid}, 32'h0);

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 16; k++) push(8'h80 + 8'(k));
    bus.i_tx_ready = 1'b1;
    push(8'hEE);
    bus.i_tx_ready = 1'b0;
    chk("pp_head", {24'h0, bus.o_tx_data}, 32'h81);
    read_status("pp_status", 32'h210);
    // dropped push and status read in one cycle: read shows old flag, set wins
    bus.i_read_req  = 1'b1;
    bus.i_read_addr = 32'd129;
    push(8'hFF);
    bus.i_read_req  = 1'b0;
    chk("setwin_rd", bus.o_read_data, 32'h210);
    read_status("setwin_ovf", 32'h610);
    read_status("setwin_clr", 32'h210);
    for (int k = 1; k < 16; k++) drain_expect("pp_drain", 8'h80 + 8'(k));
    drain_expect("pp_last", 8'hEE);
    chk("pp_empty", {31'h0, bus.o_tx_valid}, 32'h0);

    // clk_en = 0 freezes memory, FIFO and outputs
    push(8'hA1);
    push(8'hA2);
    bus.i_read_addr       = 32'd3;
    bus.i_read_fetch_addr = 32'd3;
    tick();
    chk("ce_pre_rd", bus.o_read_data, 32'hCAFEF00D);
    clk_en = 1'b0;
    bus.i_write_enable    = 1'b1;
    bus.i_byte_enable     = 4'hF;
    bus.i_write_data      = 32'h0BADF00D;
    bus.i_write_addr      = 32'd3;
    bus.i_read_addr       = 32'd5;
    bus.i_read_fetch_addr = 32'd5;
    bus.i_tx_ready        = 1'b1;
    tick();
    chk("ce_rd_hold",    bus.o_read_data, 32'hCAFEF00D);
    chk("ce_fetch_hold", bus.o_read_fetch_data, 32'hCAFEF00D);
    chk("ce_txd_hold",   {24'h0, bus.o_tx_data}, 32'hA1);
    bus.i_tx_ready = 1'b0;
    bus.i_read_req = 1'b1;
    bus.i_read_addr = 32'd129;
    push(8'hA3);
    clk_en = 1'b1;
    idle();
    bus.i_read_addr = 32'd3;
    tick();
    chk("ce_mem_kept", bus.o_read_data, 32'hCAFEF00D);
    read_status("ce_status", 32'h002);

    // reset with 5 queued bytes
    push(8'hA3);
    push(8'hA4);
    push(8'hA5);
    read_status("pre_rst_status", 32'h005);
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'h0, bus.o_tx_valid}, 32'h0);
    chk("mrst_txd",   {24'h0, bus.o_tx_data}, 32'h0);
    chk("mrst_rd",    bus.o_read_data, 32'h0);
    rst = 1'b0;
    read_status("mrst_status", 32'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
